i2c_target_regs: RTL and testbench

//  I2C target (slave) with DEPTH-byte register file; the bus-side counterpart to the i2c_top controller.

---
 rtl/i2c_target_regs_pkg.sv | 27 ++
 rtl/i2c_sync_edge.sv | 44 ++++
 rtl/i2c_target_regs.sv | 196 +++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C target: FSM states, bus-level bit meanings, bus events.
package i2c_target_regs_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8
   } i2c_state_e;

   localparam logic I2C_ACK     = 1'b0;
   localparam logic I2C_NACK    = 1'b1;
   localparam logic I2C_RW_READ = 1'b1;

   typedef struct packed {
      logic scl_rise;
      logic scl_fall;
      logic start;
      logic stop;
   } bus_evt_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Pad synchronizer for SCL/SDA plus SCL edge and START/STOP detection; shared with the controller.
module i2c_sync_edge
   import i2c_target_regs_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic     PCLK,
   input  logic     PRESETn,
   input  logic     scl_pad,
   input  logic     sda_pad,
   output logic     sda_s,
   output bus_evt_t evt
);

   logic [SYNC_STAGES-1:0] scl_pipe;
   logic [SYNC_STAGES-1:0] sda_pipe;
   logic                   scl_s;
   logic                   scl_q;
   logic                   sda_q;

   // Flops reset high so an idle bus never looks like an edge when reset lifts.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         scl_pipe <= '1;
         sda_pipe <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_pad};
         sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_pad};
         scl_q    <= scl_s;
         sda_q    <= sda_s;
      end
   end

   assign scl_s = scl_pipe[SYNC_STAGES-1];
   assign sda_s = sda_pipe[SYNC_STAGES-1];

   assign evt.scl_rise = scl_s & ~scl_q;
   assign evt.scl_fall = ~scl_s & scl_q;
   assign evt.start    = scl_s & sda_q & ~sda_s;
   assign evt.stop     = scl_s & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a DEPTH-byte register file: pointer-then-data writes, streaming reads from the pointer.
module i2c_target_regs
   import i2c_target_regs_pkg::*;
#(
   parameter  int DEPTH       = 16,
   parameter  int SYNC_STAGES = 2,
   localparam int IW          = $clog2(DEPTH)
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          i_scl_in,
   input  logic          i_sda_in,
   output logic          o_sda_out,
   output logic          o_sda_oe,
   input  logic [6:0]    i_own_addr,
   input  logic          i_en,
   output logic          o_wr_pulse,
   output logic [IW-1:0] o_wr_idx,
   output logic [7:0]    o_wr_data,
   input  logic [IW-1:0] i_host_idx,
   output logic [7:0]    o_host_data,
   output logic          o_busy,
   output logic          o_stop_evt
);

   logic                  sda_s;
   bus_evt_t              evt;

   i2c_state_e            state, state_n;
   logic [7:0]            shift, shift_n;
   logic [2:0]            bitcnt, bitcnt_n;
   logic [IW-1:0]         ptr, ptr_n;
   logic                  oe, oe_n;
   logic                  rw, rw_n;
   logic                  ack_pend, ack_pend_n;
   logic                  wr_en;
   logic                  stop_n;
   logic [7:0]            rx_byte;
   logic                  last_bit;
   logic [DEPTH-1:0][7:0] regfile;

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .scl_pad (i_scl_in),
      .sda_pad (i_sda_in),
      .sda_s   (sda_s),
      .evt     (evt)
   );

   assign rx_byte  = {shift[6:0], sda_s};
   assign last_bit = (bitcnt == 3'd7);

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state      <= ST_IDLE;
         shift      <= '0;
         bitcnt     <= '0;
         ptr        <= '0;
         oe         <= 1'b0;
         rw         <= 1'b0;
         ack_pend   <= 1'b0;
         regfile    <= '0;
         o_wr_pulse <= 1'b0;
         o_wr_idx   <= '0;
         o_wr_data  <= '0;
         o_stop_evt <= 1'b0;
      end else begin
         state      <= state_n;
         shift      <= shift_n;
         bitcnt     <= bitcnt_n;
         ptr        <= ptr_n;
         oe         <= oe_n;
         rw         <= rw_n;
         ack_pend   <= ack_pend_n;
         o_wr_pulse <= wr_en;
         o_stop_evt <= stop_n;
         if (wr_en) begin
            regfile[ptr] <= rx_byte;
            o_wr_idx     <= ptr;
            o_wr_data    <= rx_byte;
         end
      end
   end

   // ack_pend marks "8th bit taken, drive ACK (or next byte) on the coming SCL fall".
   always_comb begin
      state_n    = state;
      shift_n    = shift;
      bitcnt_n   = bitcnt;
      ptr_n      = ptr;
      oe_n       = oe;
      rw_n       = rw;
      ack_pend_n = ack_pend;
      wr_en      = 1'b0;
      stop_n     = 1'b0;

      if (evt.stop) begin
         state_n    = ST_IDLE;
         oe_n       = 1'b0;
         ack_pend_n = 1'b0;
         stop_n     = 1'b1;
      end else if (evt.start) begin
         state_n    = ST_ADDR;
         bitcnt_n   = '0;
         oe_n       = 1'b0;
         ack_pend_n = 1'b0;
      end else begin
         case (state)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (evt.scl_rise && !ack_pend) begin
                  shift_n  = rx_byte;
                  bitcnt_n = bitcnt + 3'd1;
                  if (last_bit) begin
                     ack_pend_n = 1'b1;
                     if (state == ST_ADDR) begin
                        rw_n = rx_byte[0];
                        if (!(i_en && rx_byte[7:1] == i_own_addr)) begin
                           state_n    = ST_IDLE;
                           ack_pend_n = 1'b0;
                        end
                     end else if (state == ST_PTR) begin
                        ptr_n = rx_byte[IW-1:0];
                     end else begin
                        wr_en = 1'b1;
                        ptr_n = ptr + 1'b1;
                     end
                  end
               end else if (evt.scl_fall && ack_pend) begin
                  ack_pend_n = 1'b0;
                  oe_n       = ~I2C_ACK;
                  state_n    = (state == ST_ADDR) ? ST_ADDR_ACK :
                               (state == ST_PTR)  ? ST_PTR_ACK  : ST_WDATA_ACK;
               end
            end
            ST_ADDR_ACK: begin
               if (evt.scl_fall) begin
                  bitcnt_n = '0;
                  if (rw == I2C_RW_READ) begin
                     state_n = ST_RDATA;
                     shift_n = regfile[ptr];
                     oe_n    = ~regfile[ptr][7];
                  end else begin
                     state_n = ST_PTR;
                     oe_n    = 1'b0;
                  end
               end
            end
            ST_PTR_ACK, ST_WDATA_ACK: begin
               if (evt.scl_fall) begin
                  state_n  = ST_WDATA;
                  oe_n     = 1'b0;
                  bitcnt_n = '0;
               end
            end
            ST_RDATA: begin
               if (evt.scl_fall) begin
                  if (last_bit) begin
                     state_n  = ST_RDATA_ACK;
                     oe_n     = 1'b0;
                     bitcnt_n = '0;
                  end else begin
                     shift_n  = shift << 1;
                     oe_n     = ~shift_n[7];
                     bitcnt_n = bitcnt + 3'd1;
                  end
               end
            end
            ST_RDATA_ACK: begin
               if (evt.scl_rise && !ack_pend) begin
                  if (sda_s == I2C_NACK) begin
                     state_n = ST_IDLE;
                     oe_n    = 1'b0;
                  end else begin
                     ptr_n      = ptr + 1'b1;
                     ack_pend_n = 1'b1;
                  end
               end else if (evt.scl_fall && ack_pend) begin
                  ack_pend_n = 1'b0;
                  state_n    = ST_RDATA;
                  shift_n    = regfile[ptr];
                  oe_n       = ~regfile[ptr][7];
                  bitcnt_n   = '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_sda_out   = 1'b0;
   assign o_sda_oe    = oe;
   assign o_busy      = (state != ST_IDLE);
   assign o_host_data = regfile[i_host_idx];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged I2C master on a wired-AND SDA line, write-pulse scoreboard plus bus checks.
module tb_i2c_target_regs;

   localparam int DEPTH = 16;
   localparam int IW    = 4;
   localparam int Q     = 100;   // quarter SCL period (10 PCLK)

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic          scl_m = 1'b1;
   logic          sda_m = 1'b1;
   logic          sda_line;
   logic [6:0]    i_own_addr = 7'h50;
   logic          i_en = 1'b1;
   logic [IW-1:0] i_host_idx = '0;
   logic          o_sda_out, o_sda_oe, o_wr_pulse, o_busy, o_stop_evt;
   logic [IW-1:0] o_wr_idx;
   logic [7:0]    o_wr_data, o_host_data;

   assign sda_line = sda_m & ~o_sda_oe;

   i2c_target_regs #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .i_scl_in    (scl_m),
      .i_sda_in    (sda_line),
      .o_sda_out   (o_sda_out),
      .o_sda_oe    (o_sda_oe),
      .i_own_addr  (i_own_addr),
      .i_en        (i_en),
      .o_wr_pulse  (o_wr_pulse),
      .o_wr_idx    (o_wr_idx),
      .o_wr_data   (o_wr_data),
      .i_host_idx  (i_host_idx),
      .o_host_data (o_host_data),
      .o_busy      (o_busy),
      .o_stop_evt  (o_stop_evt)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [IW-1:0] idx;
      logic [7:0]    data;
   } wr_t;

   wr_t wr_q[$];
   wr_t mon_e;
   int  n_vec = 0;
   int  n_miss = 0;
   int  stop_cnt = 0;
   int  oe_cycles = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every write pulse is matched against the next expected write.
   always @(negedge PCLK) begin
      if (o_stop_evt) stop_cnt <= stop_cnt + 1;
      if (o_sda_oe)   oe_cycles <= oe_cycles + 1;
      if (o_wr_pulse) begin
         if (wr_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL wr_unexpected: got idx %0d data %02h expected no write", o_wr_idx, o_wr_data);
         end else begin
            mon_e = wr_q.pop_front();
            chk("wr_idx", {28'd0, o_wr_idx}, {28'd0, mon_e.idx});
            chk("wr_data", {24'd0, o_wr_data}, {24'd0, mon_e.data});
         end
      end
   end

   task automatic exp_wr(input logic [IW-1:0] idx, input logic [7:0] data);
      wr_t e;
      e.idx = idx;
      e.data = data;
      wr_q.push_back(e);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b1; #Q;
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; #Q;
         scl_m = 1'b1; #(2*Q);
         scl_m = 1'b0; #Q;
      end
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      ack = sda_line; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] b);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         #Q; scl_m = 1'b1;
         #Q; b[i] = sda_line;
         #Q; scl_m = 1'b0;
         #Q;
      end
      sda_m = mack; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
   endtask

   task automatic host_chk(input string nm, input logic [IW-1:0] idx, input logic [7:0] exp);
      i_host_idx = idx;
      @(negedge PCLK);
      chk(nm, {24'd0, o_host_data}, {24'd0, exp});
   endtask

   logic       ack;
   logic [7:0] rb;
   int         oe_snap;

   initial begin
      repeat (4) @(negedge PCLK);
      chk("rst_busy", {31'd0, o_busy}, 0);
      chk("rst_oe", {31'd0, o_sda_oe}, 0);
      chk("rst_sda_out", {31'd0, o_sda_out}, 0);
      chk("rst_wr_pulse", {31'd0, o_wr_pulse}, 0);
      chk("rst_stop_evt", {31'd0, o_stop_evt}, 0);
      host_chk("rst_reg3", 4'd3, 8'h00);
      PRESETn = 1'b1;
      repeat (5) @(negedge PCLK);

      // 1: pointer 3, two data bytes
      exp_wr(4'd3, 8'h11);
      exp_wr(4'd4, 8'h22);
      bus_start();
      wr_byte(8'hA0, ack); chk("t1_addr_ack", {31'd0, ack}, 0);
      wr_byte(8'h03, ack); chk("t1_ptr_ack", {31'd0, ack}, 0);
      wr_byte(8'h11, ack); chk("t1_d0_ack", {31'd0, ack}, 0);
      wr_byte(8'h22, ack); chk("t1_d1_ack", {31'd0, ack}, 0);
      bus_stop();
      repeat (10) @(negedge PCLK);
      chk("t1_stop_cnt", stop_cnt, 1);
      host_chk("t1_host4", 4'd4, 8'h22);
      host_chk("t1_host3", 4'd3, 8'h11);

      // 2: preload 5..7, then random read of three bytes
      exp_wr(4'd5, 8'h33);
      exp_wr(4'd6, 8'h44);
      exp_wr(4'd7, 8'hC5);
      bus_start();
      wr_byte(8'hA0, ack);
      wr_byte(8'h05, ack);
      wr_byte(8'h33, ack);
      wr_byte(8'h44, ack);
      wr_byte(8'hC5, ack);
      bus_stop();
      bus_start();
      wr_byte(8'hA0, ack); chk("t2_addr_ack", {31'd0, ack}, 0);
      wr_byte(8'h05, ack); chk("t2_ptr_ack", {31'd0, ack}, 0);
      bus_start();
      wr_byte(8'hA1, ack); chk("t2_raddr_ack", {31'd0, ack}, 0);
      rd_byte(1'b0, rb); chk("t2_rd5", {24'd0, rb}, 32'h33);
      rd_byte(1'b0, rb); chk("t2_rd6", {24'd0, rb}, 32'h44);
      rd_byte(1'b1, rb); chk("t2_rd7", {24'd0, rb}, 32'hC5);
      chk("t2_oe_after_nack", {31'd0, o_sda_oe}, 0);
      chk("t2_busy_after_nack", {31'd0, o_busy}, 0);
      bus_stop();

      // 3: foreign address is ignored entirely
      repeat (5) @(negedge PCLK);
      oe_snap = oe_cycles;
      bus_start();
      wr_byte(8'hA2, ack); chk("t3_addr_nack", {31'd0, ack}, 1);
      chk("t3_busy", {31'd0, o_busy}, 0);
      wr_byte(8'h07, ack); chk("t3_data_nack", {31'd0, ack}, 1);
      chk("t3_busy2", {31'd0, o_busy}, 0);
      chk("t3_no_oe", oe_cycles - oe_snap, 0);
      bus_stop();

      // 4: pointer wrap from 15 to 0
      exp_wr(4'd15, 8'hAA);
      exp_wr(4'd0, 8'hBB);
      bus_start();
      wr_byte(8'hA0, ack);
      wr_byte(8'h0F, ack);
      wr_byte(8'hAA, ack); chk("t4_d0_ack", {31'd0, ack}, 0);
      wr_byte(8'hBB, ack); chk("t4_d1_ack", {31'd0, ack}, 0);
      bus_stop();
      host_chk("t4_host15", 4'd15, 8'hAA);
      host_chk("t4_host0", 4'd0, 8'hBB);

      // 5: enable only matters at the address phase
      i_en = 1'b0;
      bus_start();
      wr_byte(8'hA0, ack); chk("t5_dis_nack", {31'd0, ack}, 1);
      i_en = 1'b1;
      wr_byte(8'h12, ack); chk("t5_dis_data_nack", {31'd0, ack}, 1);
      bus_stop();
      bus_start();
      wr_byte(8'hA0, ack); chk("t5_en_ack", {31'd0, ack}, 0);
      wr_byte(8'h08, ack);
      exp_wr(4'd8, 8'h5A);
      i_en = 1'b0;
      wr_byte(8'h5A, ack); chk("t5_midxfer_ack", {31'd0, ack}, 0);
      i_en = 1'b1;
      bus_stop();
      host_chk("t5_host8", 4'd8, 8'h5A);

      // 6: reset in the middle of a data byte
      bus_start();
      wr_byte(8'hA0, ack);
      wr_byte(8'h02, ack);
      for (int i = 7; i >= 4; i--) begin
         sda_m = i[0]; #Q;
         scl_m = 1'b1; #(2*Q);
         scl_m = 1'b0; #Q;
      end
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      PRESETn = 1'b0;
      repeat (3) @(negedge PCLK);
      chk("t6_oe_rst", {31'd0, o_sda_oe}, 0);
      chk("t6_busy_rst", {31'd0, o_busy}, 0);
      scl_m = 1'b0; #Q;
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      PRESETn = 1'b1;
      repeat (5) @(negedge PCLK);
      for (int i = 0; i < DEPTH; i++) host_chk("t6_reg_clear", i[IW-1:0], 8'h00);
      bus_start();
      wr_byte(8'hA0, ack); chk("t6_post_ack", {31'd0, ack}, 0);
      bus_stop();

      repeat (20) @(negedge PCLK);
      chk("wr_q_drained", wr_q.size(), 0);
      chk("stop_total", stop_cnt, 8);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
